ym_zbank: RTL and testbench
===========================

YM_ZBANK -- requirements
Module: ym_zbank

Interface
REQ-001 SHALL expose parameter BANK_PAGE, default 8'h60, meaning the ZA[15:8] value that selects the bank register.
REQ-002 SHALL expose ports exactly as listed below; one clock; reset is asynchronous and active-low.
- MCLK  in  1  master clock; all state on its rising edge.
- SRES  in  1  asynchronous active-low reset.
- ZCLK  in  1  Z80 clock, used only as a sampled enable (rising-edge detected in the MCLK domain).
- ZA_i  in  16  Z80 address.
- ZD0_i  in  1  Z80 data bit 0.
- MREQ  in  1  Z80 memory request, active-low.
- ZRD  in  1  Z80 read strobe, active-low.
- ZWR  in  1  Z80 write strobe, active-low.
- WDONE  in  1  arbiter pulse: the current window access has completed.
- VA_o  out  16  68k address bits 22:7 for the window.
- VA23_o  out  1  68k address bit 23.
- WREQ  out  1  window access request to the arbiter, active-high.
- WRNW  out  1  latched direction of the window access: 1 = read.
- BANK  out  9  bank register contents (A23..A15).

Function
REQ-003 zedge SHALL be true on an MCLK edge where ZCLK=1 and the previous MCLK sample of ZCLK was 0; all Z80-side inputs are sampled only on zedge.
REQ-004 Bank write SHALL be: zedge, MREQ=0, ZWR=0, ZA_i[15:8]=BANK_PAGE, and no shift yet in this write cycle.
- On bank write: BANK <= {ZD0_i, BANK[8:1]}.
REQ-005 Exactly one shift per Z80 write cycle; a further shift needs ZWR or MREQ sampled high on a later zedge.
REQ-006 VA_o[22:15] SHALL equal BANK[7:0], VA_o[14:7] SHALL equal ZA_i[14:7], and VA23_o SHALL equal BANK[8]; these outputs are combinational from the registers and inputs.
REQ-007 The FSM SHALL have three states: IDLE, REQ and HOLD.
REQ-008 IDLE->REQ SHALL occur on zedge with MREQ=0, ZA_i[15]=1 and (ZRD=0 or ZWR=0).
- On that transition WRNW <= ~ZRD.
REQ-009 WREQ SHALL be 1 only in REQ. It is registered and goes high on the MCLK edge after the qualifying zedge sample.
REQ-010 REQ->HOLD SHALL occur on any MCLK edge with WDONE=1, independent of zedge.
REQ-011 HOLD->IDLE SHALL occur on zedge with MREQ=1, so that one Z80 cycle produces exactly one request.
REQ-012 While the FSM is in REQ or HOLD, WRNW SHALL hold its value, and changes on ZRD/ZWR SHALL be ignored.
REQ-013 WDONE in IDLE or HOLD SHALL be ignored.
REQ-014 If WDONE=1 coincides with the request-qualifying zedge in IDLE, the FSM SHALL enter REQ; that WDONE is not consumed.
REQ-015 A bank write (ZA15=0) SHALL never raise WREQ, and a window access SHALL never shift BANK.
REQ-016 Concurrent ZRD=0 and ZWR=0 SHALL be treated as a read (WRNW=1).

Reset
REQ-017 SRES=0 SHALL immediately force the following, regardless of MCLK:
- BANK=0, state=IDLE, WREQ=0, WRNW=1.
- ZCLK history=1, so that no spurious zedge follows release.
- shift-done flag=0.
REQ-018 Reset during REQ SHALL drop WREQ without waiting for WDONE.
REQ-019 After reset release, the first zedge SHALL require an observed ZCLK low sample first.

Structure
REQ-020 Shared package ym_zbank_pkg SHALL hold the following:
- the state enum (IDLE, REQ, HOLD);
- BANK_W=9;
- the default BANK_PAGE.
REQ-021 Sub-module ym_zbank_shreg SHALL hold the 9-bit shift register with its one-shot write qualifier. The FSM and edge detector stay in ym_zbank.

Verification
REQ-022 Reset then nine bank writes with ZD0=1,0,0,0,0,0,0,0,0 -> BANK=9'h001; then ZA_i=16'h80C0 -> VA_o=16'h0101, VA23_o=0.
REQ-023 Nine writes all ZD0=1 -> BANK=9'h1FF, VA23_o=1. A tenth write with ZD0=0 -> BANK=9'h0FF.
REQ-024 Bank write with ZWR held low across 5 ZCLK periods -> exactly one shift.
REQ-025 Window read at ZA=16'h9000:
- WREQ=1 one MCLK after the qualifying zedge, WRNW=1.
- WDONE pulse -> WREQ=0 next edge.
- No second WREQ until MREQ is sampled high and a new access begins.
REQ-026 Window write, with SRES pulsed low while WREQ=1 -> WREQ=0 and BANK=0 immediately. After release, no WREQ until a new qualifying zedge.
REQ-027 WDONE asserted in IDLE and in HOLD -> no state change. Write to ZA=16'h6000 -> WREQ stays 0 and BANK shifts once.

Source files
------------

// File: rtl/ym_zbank_pkg.sv
// Shared types and constants for the Z80 bank window block.
package ym_zbank_pkg;

    // Window access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Bank register width: 68k address bits A23..A15.
    localparam int BANK_W = 9;

    // ZA[15:8] page that addresses the bank register.
    localparam logic [7:0] BANK_PAGE_DEF = 8'h60;

endpackage

// File: rtl/ym_zbank_shreg.sv
// 9-bit serial bank register. Each Z80 write to the bank page shifts ZD0
// in at the top; a one-shot flag limits this to one shift per write cycle.
module ym_zbank_shreg
    import ym_zbank_pkg::*;
(
    input  logic              MCLK,
    input  logic              SRES,
    input  logic              zedge,
    input  logic              mreq,
    input  logic              zwr,
    input  logic              page_hit,
    input  logic              zd0,
    output logic [BANK_W-1:0] bank
);

    // Set once a shift has happened in the current write cycle; cleared when
    // the cycle ends (MREQ or ZWR seen high on a Z80 clock edge).
    logic shift_done;

    // Shift register and its one-shot qualifier, updated only on Z80 clock edges.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            bank       <= '0;
            shift_done <= 1'b0;
        end else if (zedge) begin
            if (mreq || zwr) begin
                shift_done <= 1'b0;
            end else if (page_hit && !shift_done) begin
                bank       <= {zd0, bank[BANK_W-1:1]};
                shift_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ym_zbank.sv
// Z80 bank window: a serial bank register supplies 68k A23..A15 and a small
// sequencer raises one arbiter request per Z80 access to the upper 32 KB.
//
// Handshake: WREQ is held high from the first Z80 clock edge that qualifies
// an access until the arbiter returns a one-cycle WDONE pulse; WRNW is valid
// and stable for the whole time WREQ is high. A new request can only start
// after MREQ has been seen high, so each Z80 cycle yields one request.
module ym_zbank
    import ym_zbank_pkg::*;
#(
    parameter logic [7:0] BANK_PAGE = BANK_PAGE_DEF
) (
    input  logic              MCLK,
    input  logic              SRES,
    input  logic              ZCLK,
    input  logic [15:0]       ZA_i,
    input  logic              ZD0_i,
    input  logic              MREQ,
    input  logic              ZRD,
    input  logic              ZWR,
    input  logic              WDONE,
    output logic [15:0]       VA_o,
    output logic              VA23_o,
    output logic              WREQ,
    output logic              WRNW,
    output logic [BANK_W-1:0] BANK
);

    logic   zclk_q;
    logic   zedge;
    state_t state;
    state_t state_nxt;
    logic   wrnw_nxt;
    logic   win_hit;
    logic   unused_za;

    // Low address bits never reach the 68k side of the window.
    assign unused_za = ^ZA_i[6:0];

    // ZCLK history resets high so a ZCLK already high at release is not an edge.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) zclk_q <= 1'b1;
        else       zclk_q <= ZCLK;
    end

    assign zedge   = ZCLK && !zclk_q;
    assign win_hit = !MREQ && ZA_i[15] && (!ZRD || !ZWR);

    ym_zbank_shreg u_shreg (
        .MCLK     (MCLK),
        .SRES     (SRES),
        .zedge    (zedge),
        .mreq     (MREQ),
        .zwr      (ZWR),
        .page_hit (ZA_i[15:8] == BANK_PAGE),
        .zd0      (ZD0_i),
        .bank     (BANK)
    );

    assign VA_o   = {BANK[7:0], ZA_i[14:7]};
    assign VA23_o = BANK[8];

    // Sequencer next state; direction is captured only when a request starts,
    // with a simultaneous read and write strobe counted as a read.
    always_comb begin
        state_nxt = state;
        wrnw_nxt  = WRNW;
        case (state)
            IDLE: begin
                if (zedge && win_hit) begin
                    state_nxt = REQ;
                    wrnw_nxt  = ~ZRD;
                end
            end
            REQ: begin
                if (WDONE) state_nxt = HOLD;
            end
            HOLD: begin
                if (zedge && MREQ) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencer state plus registered request and direction outputs.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            state <= IDLE;
            WREQ  <= 1'b0;
            WRNW  <= 1'b1;
        end else begin
            state <= state_nxt;
            WREQ  <= (state_nxt == REQ);
            WRNW  <= wrnw_nxt;
        end
    end

endmodule

// File: tb/tb_ym_zbank.sv
// Bench for ym_zbank: table of bank writes, hand sequences for the window
// handshake corners, then random Z80 cycles against a transaction model.
module tb_ym_zbank;

    logic        MCLK = 1'b0;
    logic        SRES;
    logic        ZCLK;
    logic [15:0] ZA_i;
    logic        ZD0_i;
    logic        MREQ;
    logic        ZRD;
    logic        ZWR;
    logic        WDONE;
    logic [15:0] VA_o;
    logic        VA23_o;
    logic        WREQ;
    logic        WRNW;
    logic [8:0]  BANK;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] ref_bank;

    typedef struct {
        logic        zd0;
        logic [8:0]  exp_bank;
        logic [15:0] exp_va;
        logic        exp_va23;
    } vec_t;

    vec_t tbl[19];

    ym_zbank dut (
        .MCLK   (MCLK),
        .SRES   (SRES),
        .ZCLK   (ZCLK),
        .ZA_i   (ZA_i),
        .ZD0_i  (ZD0_i),
        .MREQ   (MREQ),
        .ZRD    (ZRD),
        .ZWR    (ZWR),
        .WDONE  (WDONE),
        .VA_o   (VA_o),
        .VA23_o (VA23_o),
        .WREQ   (WREQ),
        .WRNW   (WRNW),
        .BANK   (BANK)
    );

    // Clock and watchdog.
    always #5 MCLK = ~MCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One Z80 clock period: low for one MCLK, then high; returns 1ns after
    // the MCLK edge that sees the rising ZCLK.
    task automatic zt();
        @(negedge MCLK) ZCLK = 1'b0;
        @(negedge MCLK) ZCLK = 1'b1;
        @(posedge MCLK);
        #1;
    endtask

    task automatic z_idle();
        MREQ = 1'b1; ZRD = 1'b1; ZWR = 1'b1;
        zt();
    endtask

    task automatic wdone_pulse();
        @(negedge MCLK) WDONE = 1'b1;
        @(posedge MCLK);
        #1 WDONE = 1'b0;
    endtask

    task automatic bank_wr(input logic d);
        ZA_i = 16'h6000; ZD0_i = d;
        MREQ = 1'b0; ZRD = 1'b1; ZWR = 1'b0;
        zt();
        z_idle();
    endtask

    // Transaction-level model: the bank is a number that takes the new bit
    // as its top bit; a window access is one request per Z80 cycle.
    function automatic logic [8:0] model_shift(input logic [8:0] b, input logic d);
        return (b / 2) + (d ? 9'd256 : 9'd0);
    endfunction

    initial begin
        tbl[0]  = '{1'b1, 9'h100, 16'h0001, 1'b1};
        tbl[1]  = '{1'b0, 9'h080, 16'h8001, 1'b0};
        tbl[2]  = '{1'b0, 9'h040, 16'h4001, 1'b0};
        tbl[3]  = '{1'b0, 9'h020, 16'h2001, 1'b0};
        tbl[4]  = '{1'b0, 9'h010, 16'h1001, 1'b0};
        tbl[5]  = '{1'b0, 9'h008, 16'h0801, 1'b0};
        tbl[6]  = '{1'b0, 9'h004, 16'h0401, 1'b0};
        tbl[7]  = '{1'b0, 9'h002, 16'h0201, 1'b0};
        tbl[8]  = '{1'b0, 9'h001, 16'h0101, 1'b0};
        tbl[9]  = '{1'b1, 9'h100, 16'h0001, 1'b1};
        tbl[10] = '{1'b1, 9'h180, 16'h8001, 1'b1};
        tbl[11] = '{1'b1, 9'h1C0, 16'hC001, 1'b1};
        tbl[12] = '{1'b1, 9'h1E0, 16'hE001, 1'b1};
        tbl[13] = '{1'b1, 9'h1F0, 16'hF001, 1'b1};
        tbl[14] = '{1'b1, 9'h1F8, 16'hF801, 1'b1};
        tbl[15] = '{1'b1, 9'h1FC, 16'hFC01, 1'b1};
        tbl[16] = '{1'b1, 9'h1FE, 16'hFE01, 1'b1};
        tbl[17] = '{1'b1, 9'h1FF, 16'hFF01, 1'b1};
        tbl[18] = '{1'b0, 9'h0FF, 16'hFF01, 1'b0};

        // Reset.
        SRES = 1'b0; ZCLK = 1'b0; ZA_i = 16'h0000; ZD0_i = 1'b0;
        MREQ = 1'b1; ZRD = 1'b1; ZWR = 1'b1; WDONE = 1'b0;
        #23;
        chk("reset_bank", {7'd0, BANK}, 16'h0000);
        chk("reset_wreq", {15'd0, WREQ}, 16'h0000);
        chk("reset_wrnw", {15'd0, WRNW}, 16'h0001);
        chk("reset_va23", {15'd0, VA23_o}, 16'h0000);
        @(negedge MCLK) SRES = 1'b1;

        // Table: bank writes, then view the window address through VA.
        foreach (tbl[i]) begin
            bank_wr(tbl[i].zd0);
            ZA_i = 16'h80C0;
            #1;
            chk($sformatf("tbl%0d_bank", i), {7'd0, BANK}, {7'd0, tbl[i].exp_bank});
            chk($sformatf("tbl%0d_va", i), VA_o, tbl[i].exp_va);
            chk($sformatf("tbl%0d_va23", i), {15'd0, VA23_o}, {15'd0, tbl[i].exp_va23});
            chk($sformatf("tbl%0d_wreq", i), {15'd0, WREQ}, 16'h0000);
        end
        ref_bank = 9'h0FF;

        // Write strobe held low across five Z80 clocks: one shift only.
        ZA_i = 16'h60AA; ZD0_i = 1'b1; MREQ = 1'b0; ZRD = 1'b1; ZWR = 1'b0;
        for (int k = 0; k < 5; k++) zt();
        ref_bank = model_shift(ref_bank, 1'b1);
        chk("long_wr_bank", {7'd0, BANK}, {7'd0, ref_bank});
        chk("long_wr_wreq", {15'd0, WREQ}, 16'h0000);
        z_idle();

        // Window read at 9000.
        ZA_i = 16'h9000; MREQ = 1'b0; ZRD = 1'b0; ZWR = 1'b1;
        @(negedge MCLK) ZCLK = 1'b0;
        @(negedge MCLK) ZCLK = 1'b1;
        #1 chk("rd_wreq_before_edge", {15'd0, WREQ}, 16'h0000);
        @(posedge MCLK); #1;
        chk("rd_wreq", {15'd0, WREQ}, 16'h0001);
        chk("rd_wrnw", {15'd0, WRNW}, 16'h0001);
        zt();
        chk("rd_wreq_hold", {15'd0, WREQ}, 16'h0001);
        wdone_pulse();
        chk("rd_wreq_done", {15'd0, WREQ}, 16'h0000);
        zt(); zt();
        chk("rd_no_second_req", {15'd0, WREQ}, 16'h0000);
        ZRD = 1'b1; ZWR = 1'b0;
        zt();
        chk("rd_wrnw_frozen", {15'd0, WRNW}, 16'h0001);
        chk("rd_no_req_wr_change", {15'd0, WREQ}, 16'h0000);
        wdone_pulse();
        chk("hold_wdone_ignored", {15'd0, WREQ}, 16'h0000);
        z_idle();
        chk("rd_idle_wreq", {15'd0, WREQ}, 16'h0000);
        wdone_pulse();
        chk("idle_wdone_ignored", {15'd0, WREQ}, 16'h0000);
        chk("rd_bank_kept", {7'd0, BANK}, {7'd0, ref_bank});

        // Both strobes low counts as a read.
        ZA_i = 16'hC123; MREQ = 1'b0; ZRD = 1'b0; ZWR = 1'b0;
        zt();
        chk("both_wreq", {15'd0, WREQ}, 16'h0001);
        chk("both_wrnw", {15'd0, WRNW}, 16'h0001);
        wdone_pulse();
        z_idle();

        // WDONE arriving with the qualifying edge does not skip REQ.
        ZA_i = 16'hA000; MREQ = 1'b0; ZRD = 1'b1; ZWR = 1'b0;
        @(negedge MCLK) ZCLK = 1'b0;
        @(negedge MCLK) begin ZCLK = 1'b1; WDONE = 1'b1; end
        @(posedge MCLK); #1 WDONE = 1'b0;
        chk("coinc_wreq", {15'd0, WREQ}, 16'h0001);
        chk("coinc_wrnw", {15'd0, WRNW}, 16'h0000);
        @(posedge MCLK); #1;
        chk("coinc_wreq_kept", {15'd0, WREQ}, 16'h0001);
        wdone_pulse();
        z_idle();

        // Reset while a window write is pending.
        ZA_i = 16'hF0F0; MREQ = 1'b0; ZRD = 1'b1; ZWR = 1'b0;
        zt();
        chk("rst_pre_wreq", {15'd0, WREQ}, 16'h0001);
        #2 SRES = 1'b0;
        #1;
        chk("rst_async_wreq", {15'd0, WREQ}, 16'h0000);
        chk("rst_async_bank", {7'd0, BANK}, 16'h0000);
        chk("rst_async_wrnw", {15'd0, WRNW}, 16'h0001);
        ref_bank = 9'h000;
        @(negedge MCLK) SRES = 1'b1;
        repeat (4) @(posedge MCLK);
        #1 chk("rst_no_spurious_req", {15'd0, WREQ}, 16'h0000);
        zt();
        chk("rst_new_req", {15'd0, WREQ}, 16'h0001);
        chk("rst_new_wrnw", {15'd0, WRNW}, 16'h0000);
        wdone_pulse();
        z_idle();

        // Write to bank page 6000: shifts once, never requests.
        ZA_i = 16'h6000; ZD0_i = 1'b1; MREQ = 1'b0; ZRD = 1'b1; ZWR = 1'b0;
        zt();
        chk("p6000_wreq", {15'd0, WREQ}, 16'h0000);
        z_idle();
        ref_bank = model_shift(ref_bank, 1'b1);
        chk("p6000_bank", {7'd0, BANK}, {7'd0, ref_bank});

        // Random Z80 cycles against the transaction model.
        for (int t = 0; t < 60; t++) begin
            int kind;
            int rw;
            int n;
            logic [7:0] pg;
            logic rd_l;
            logic wr_l;
            logic d;
            kind = $urandom_range(0, 2);
            rw   = $urandom_range(0, 2);
            n    = $urandom_range(1, 3);
            d    = 1'($urandom_range(0, 1));
            rd_l = (rw == 1);
            wr_l = (rw == 0);
            if (kind == 0)      pg = 8'h60;
            else if (kind == 1) pg = 8'($urandom_range(128, 255));
            else begin
                pg = 8'($urandom_range(0, 127));
                if (pg == 8'h60) pg = 8'h61;
            end
            ZA_i = {pg, 8'($urandom_range(0, 255))};
            ZD0_i = d; MREQ = 1'b0; ZRD = rd_l; ZWR = wr_l;
            if (kind == 0 && !wr_l) ref_bank = model_shift(ref_bank, d);
            exp_q.push_back(ref_bank);
            for (int k = 0; k < n; k++) begin
                zt();
                chk($sformatf("rnd%0d_wreq", t), {15'd0, WREQ}, {15'd0, kind == 1});
            end
            if (kind == 1) begin
                chk($sformatf("rnd%0d_wrnw", t), {15'd0, WRNW}, {15'd0, !rd_l});
                wdone_pulse();
                chk($sformatf("rnd%0d_done", t), {15'd0, WREQ}, 16'h0000);
            end
            z_idle();
            chk($sformatf("rnd%0d_bank", t), {7'd0, BANK}, {7'd0, exp_q.pop_front()});
            chk($sformatf("rnd%0d_va23", t), {15'd0, VA23_o}, {15'd0, ref_bank[8]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
